first_nios2_system_sysid_checker: RTL

//  Avalon-MM master that reads the system ID slave. It reads word 0 (system ID), then word 1 (build timestamp).

---
 rtl/first_nios2_system_sysid_checker_pkg.sv | 28 ++
 rtl/first_nios2_system_sysid_checker_if.sv | 28 ++
 rtl/first_nios2_system_sysid_checker_wdog.sv | 46 ++++
 rtl/first_nios2_system_sysid_checker.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/first_nios2_system_sysid_checker_pkg.sv
// Shared types and constants for the sysid checker.
// Holds the FSM state encoding, the sysid word addresses and the result flag bundle.
package first_nios2_system_sysid_checker_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    // Word addresses inside the sysid control_slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Sticky result flags reported for the last sequence
    typedef struct packed {
        logic pass;
        logic id_ok;
        logic ts_ok;
        logic timeout;
    } flags_t;

endpackage

// File: rtl/first_nios2_system_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
//   address     : 0 = system ID, 1 = build timestamp
//   read        : read strobe
//   waitrequest : slave stall
//   readdata    : read data, valid when read && !waitrequest
interface first_nios2_system_sysid_checker_if;
    import first_nios2_system_sysid_checker_pkg::*;

    logic              address;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );

endinterface

// File: rtl/first_nios2_system_sysid_checker_wdog.sv
// Saturating waitrequest counter for one Avalon read.
//   clock, reset : system clock, async active-high reset
//   stall        : read pending and slave stalling this cycle
//   clr          : read accepted this cycle
//   expired_c    : combinational; this stall cycle is the LIMIT-th in a row
module first_nios2_system_sysid_checker_wdog
    import first_nios2_system_sysid_checker_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    input  logic clr,
    output logic expired_c
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry is flagged on the stall cycle that would bring the count to LIMIT,
    // so the read strobe is high for exactly LIMIT stalled cycles.
    assign expired_c = stall && (count_q >= CNT_LIMIT);

    // Count stalls, saturate at max, restart on accept or abort
    always_comb begin
        count_d = count_q;
        if (clr || expired_c) begin
            count_d = '0;
        end else if (stall && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Reads the sysid slave (ID word then timestamp word), compares both against the
// expected build values and reports a sticky pass/fail so a mismatched
// hardware/software image is caught before the CPU boots.
//   clock, reset         : system clock, async active-high reset
//   start                : pulse, requests a check sequence (ignored while busy)
//   avm                  : Avalon-MM master to the sysid control_slave
//   busy, done           : sequence in progress / one-cycle end pulse
//   pass, id_ok, ts_ok   : sticky compare results of the last sequence
//   timeout              : sticky, last sequence aborted on waitrequest
//   id_value, ts_value   : last captured words
module first_nios2_system_sysid_checker
    import first_nios2_system_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h5139_FA40,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    first_nios2_system_sysid_checker_if.master   avm,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic                                 id_ok,
    output logic                                 ts_ok,
    output logic                                 timeout,
    output logic [DATA_W-1:0]                    id_value,
    output logic [DATA_W-1:0]                    ts_value
);

    state_e            state_q,    state_d;
    logic              auto_q,     auto_d;
    logic              read_q,     read_d;
    logic              address_q,  address_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    flags_t            flags_q,    flags_d;
    logic [DATA_W-1:0] id_value_q, id_value_d;
    logic [DATA_W-1:0] ts_value_q, ts_value_d;

    logic stall_c;
    logic accept_c;
    logic expired_c;

    assign stall_c  = read_q &&  avm.waitrequest;
    assign accept_c = read_q && !avm.waitrequest;

    first_nios2_system_sysid_checker_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall_c),
        .clr       (accept_c),
        .expired_c (expired_c)
    );

    // Next state, capture and flag update; bus/status outputs derive from next state
    always_comb begin
        state_d    = state_q;
        auto_d     = 1'b0;
        flags_d    = flags_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        read_d     = 1'b0;
        address_d  = ADDR_ID;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // auto_q is only set on the first cycle after reset
                if (start || auto_q) begin
                    state_d = ST_RD_ID;
                    flags_d = '0;
                end
            end
            ST_RD_ID: begin
                if (accept_c) begin
                    id_value_d = avm.readdata;
                    state_d    = ST_RD_TS;
                end else if (expired_c) begin
                    flags_d.timeout = 1'b1;
                    state_d         = ST_DONE;
                end
            end
            ST_RD_TS: begin
                if (accept_c) begin
                    ts_value_d = avm.readdata;
                    state_d    = ST_CMP;
                end else if (expired_c) begin
                    flags_d.timeout = 1'b1;
                    state_d         = ST_DONE;
                end
            end
            ST_CMP: begin
                flags_d.id_ok = (id_value_q == EXPECTED_ID);
                flags_d.ts_ok = (ts_value_q == EXPECTED_TS);
                flags_d.pass  = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                // start arriving alongside the done pulse is dropped
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        read_d    = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
        address_d = (state_d == ST_RD_TS) ? ADDR_TS : ADDR_ID;
        busy_d    = (state_d == ST_RD_ID) || (state_d == ST_RD_TS) || (state_d == ST_CMP);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            auto_q     <= AUTO_START;
            read_q     <= 1'b0;
            address_q  <= ADDR_ID;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flags_q    <= '0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            read_q     <= read_d;
            address_q  <= address_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flags_q    <= flags_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign avm.read    = read_q;
    assign avm.address = address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = flags_q.pass;
    assign id_ok       = flags_q.id_ok;
    assign ts_ok       = flags_q.ts_ok;
    assign timeout     = flags_q.timeout;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule
